// File: rtl/rv32_cpu_pkg.sv
// Shared RV32I constants: opcodes, funct3/funct7 fields, ALU-op encoding and the ALU itself.
package rv32_cpu_pkg;

   // major opcodes
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   // ALU funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // load / store funct3
   localparam logic [2:0] F3_LB   = 3'b000;
   localparam logic [2:0] F3_LH   = 3'b001;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_LHU  = 3'b101;
   localparam logic [2:0] F3_SB   = 3'b000;
   localparam logic [2:0] F3_SH   = 3'b001;
   localparam logic [2:0] F3_SW   = 3'b010;

   // funct7 selecting SUB / SRA / SRAI
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
   } alu_op_e;

   // funct3 + alternate bit -> ALU operation
   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // 32-bit wrapping ALU; shift amount is b[4:0]
   function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << sh;
         ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'b0, a < b};
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> sh;
         ALU_SRA:  return $signed(a) >>> sh;
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return a + b;
      endcase
   endfunction

endpackage

// File: rtl/rv32_cpu_imem.sv
// Read-only instruction memory, word addressed, combinational read. Loaded hierarchically.
module rv32_cpu_imem #(
   parameter int WORDS = 256,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic [AW-1:0] addr,
   output logic [31:0]   data
);

   reg [31:0] RAM [0:WORDS-1];

   assign data = RAM[addr];

endmodule

// File: rtl/rv32_cpu.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback all retire on one edge.
module rv32_cpu
   import rv32_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter int          IMEM_WORDS = 256,
   parameter int          DMEM_WORDS = 256
) (
   input logic clk,
   input logic rstn    // active-high despite the name
);

   localparam int          IA      = $clog2(IMEM_WORDS);
   localparam int          DA      = $clog2(DMEM_WORDS);
   localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

   logic [31:0] pc, instr, pc_seq, pc_nxt;
   logic [31:0] rf   [0:31];
   logic [31:0] dram [0:DMEM_WORDS-1];

   rv32_cpu_imem #(.WORDS(IMEM_WORDS)) imem (.addr(pc[IA+1:2]), .data(instr));

   // decode
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        alt;
   logic [31:0] rs1v, rs2v;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign alt    = (instr[31:25] == F7_ALT);

   assign rs1v = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
   assign rs2v = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // ALU: also forms load/store addresses and the JALR target (ADD with imm by default)
   alu_op_e     alu_op;
   logic [31:0] alu_b, alu_y;

   // select ALU operation and second operand
   always_comb begin
      alu_op = ALU_ADD;
      alu_b  = imm_i;
      case (opcode)
         OP_OP: begin
            alu_op = alu_decode(f3, alt);
            alu_b  = rs2v;
         end
         OP_IMM:   alu_op = alu_decode(f3, (f3 == F3_SR) && alt);  // ADDI never subtracts
         OP_STORE: alu_b  = imm_s;
         default:  ;
      endcase
   end

   assign alu_y = alu(alu_op, rs1v, alu_b);

   // branch condition
   logic br_take;

   // evaluate branch compare for the current funct3
   always_comb begin
      br_take = 1'b0;
      case (f3)
         F3_BEQ:  br_take = (rs1v == rs2v);
         F3_BNE:  br_take = (rs1v != rs2v);
         F3_BLT:  br_take = ($signed(rs1v) <  $signed(rs2v));
         F3_BGE:  br_take = ($signed(rs1v) >= $signed(rs2v));
         F3_BLTU: br_take = (rs1v <  rs2v);
         F3_BGEU: br_take = (rs1v >= rs2v);
         default: br_take = 1'b0;
      endcase
   end

   // data memory: misaligned halves/words simply use the aligned word
   logic [31:0] dword, ld, st_data;
   logic [7:0]  lbyte;
   logic [15:0] lhalf;
   logic [3:0]  st_be;

   assign dword = dram[alu_y[DA+1:2]];

   // load lane extraction and extension
   always_comb begin
      lbyte = dword[{alu_y[1:0], 3'b000} +: 8];
      lhalf = alu_y[1] ? dword[31:16] : dword[15:0];
      ld    = dword;
      case (f3)
         F3_LB:   ld = {{24{lbyte[7]}}, lbyte};
         F3_LH:   ld = {{16{lhalf[15]}}, lhalf};
         F3_LW:   ld = dword;
         F3_LBU:  ld = {24'b0, lbyte};
         F3_LHU:  ld = {16'b0, lhalf};
         default: ld = dword;
      endcase
   end

   // store byte-lane enables and replicated write data
   always_comb begin
      st_be   = 4'b0000;
      st_data = rs2v;
      if (opcode == OP_STORE) begin
         case (f3)
            F3_SB: begin
               st_be   = 4'b0001 << alu_y[1:0];
               st_data = {4{rs2v[7:0]}};
            end
            F3_SH: begin
               st_be   = alu_y[1] ? 4'b1100 : 4'b0011;
               st_data = {2{rs2v[15:0]}};
            end
            F3_SW:   st_be = 4'b1111;
            default: ;
         endcase
      end
   end

   // dmem byte-lane write; contents survive reset, nothing retires while reset is held
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int b = 0; b < 4; b++)
            if (st_be[b]) dram[alu_y[DA+1:2]][8*b +: 8] <= st_data[8*b +: 8];
      end
   end

   // writeback data and next pc
   logic        wb_en;
   logic [31:0] wb_data;

   assign pc_seq = pc + 32'd4;

   // per-opcode writeback enable/data and next-pc selection; unknown opcodes fall through as NOPs
   always_comb begin
      wb_en   = 1'b0;
      wb_data = alu_y;
      pc_nxt  = pc_seq;
      case (opcode)
         OP_LUI: begin
            wb_en   = 1'b1;
            wb_data = imm_u;
         end
         OP_AUIPC: begin
            wb_en   = 1'b1;
            wb_data = pc + imm_u;
         end
         OP_JAL: begin
            wb_en   = 1'b1;
            wb_data = pc_seq;
            pc_nxt  = pc + imm_j;
         end
         OP_JALR: begin
            wb_en   = 1'b1;
            wb_data = pc_seq;
            pc_nxt  = {alu_y[31:1], 1'b0};
         end
         OP_BRANCH: if (br_take) pc_nxt = pc + imm_b;
         OP_LOAD: begin
            wb_en   = 1'b1;
            wb_data = ld;
         end
         OP_IMM, OP_OP: wb_en = 1'b1;
         default: ;
      endcase
   end

   // pc register; wraps within the instruction memory span
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) pc <= RESET_PC;
      else      pc <= pc_nxt & PC_MASK;
   end

   // register file write port; x0 is never written so it stays zero
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (wb_en && (rd != 5'd0)) begin
         rf[rd] <= wb_data;
      end
   end

endmodule

// File: tb/tb_rv32_cpu.sv
// Directed bench for rv32_cpu: small hand-assembled programs, hierarchical observation.
module tb_rv32_cpu;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   rv32_cpu #(.RESET_PC(32'h0), .IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
      .clk  (clk),
      .rstn (rstn)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
   localparam logic [6:0] BR  = 7'h63, LD = 7'h03, ST = 7'h23, IMM = 7'h13, OPR = 7'h33;

   // instruction encoders
   function automatic logic [31:0] ei(input logic [31:0] imm, input logic [31:0] rs1,
                                      input logic [31:0] f3, input logic [31:0] rd, input logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] er(input logic [31:0] f7, input logic [31:0] rs2,
                                      input logic [31:0] rs1, input logic [31:0] f3, input logic [31:0] rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
   endfunction
   function automatic logic [31:0] es(input logic [31:0] imm, input logic [31:0] rs2,
                                      input logic [31:0] rs1, input logic [31:0] f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], ST};
   endfunction
   function automatic logic [31:0] eb(input logic [31:0] imm, input logic [31:0] rs2,
                                      input logic [31:0] rs1, input logic [31:0] f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], BR};
   endfunction
   function automatic logic [31:0] eu(input logic [31:0] imm, input logic [31:0] rd, input logic [6:0] op);
      return {imm[19:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] ej(input logic [31:0] imm, input logic [31:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], JAL};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // hold reset and blank the instruction memory (all-zero words are NOPs)
   task automatic begin_phase();
      rstn = 1'b1;
      for (int i = 0; i < 256; i++) dut.imem.RAM[i] = 32'h0;
   endtask

   task automatic put(input logic [31:0] addr, input logic [31:0] w);
      dut.imem.RAM[addr[9:2]] = w;
   endtask

   task automatic release_rst();
      @(negedge clk);
      rstn = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [31:0] w0;
   logic [31:0] exp_rf [0:31];
   int          cyc;

   initial begin
      // ---------------- reset + ALU ----------------
      begin_phase();
      w0 = ei(-3, 0, 0, 1, IMM);
      put(32'h00, w0);                       // addi x1,x0,-3
      put(32'h04, ei(5, 0, 0, 2, IMM));      // addi x2,x0,5
      put(32'h08, er(0, 2, 1, 0, 3));        // add  x3,x1,x2
      put(32'h0C, er(0, 2, 1, 2, 4));        // slt  x4,x1,x2
      put(32'h10, er(0, 2, 1, 3, 5));        // sltu x5,x1,x2
      put(32'h14, ei(32'h401, 1, 5, 6, IMM));// srai x6,x1,1
      put(32'h18, ei(1, 0, 0, 12, IMM));     // addi x12,x0,1
      put(32'h1C, er(32, 12, 1, 5, 11));     // sra  x11,x1,x12
      #5;
      release_rst();
      chk("rst_pc", dut.pc, 32'h0);
      chk("rst_instr", dut.instr, w0);
      chk("rst_x5", dut.rf[5], 32'h0);
      step(8);
      chk("alu_pc", dut.pc, 32'h20);
      chk("alu_x1", dut.rf[1], 32'hFFFF_FFFD);
      chk("alu_add", dut.rf[3], 32'h2);
      chk("alu_slt", dut.rf[4], 32'h1);
      chk("alu_sltu", dut.rf[5], 32'h0);
      chk("alu_srai", dut.rf[6], 32'hFFFF_FFFE);
      chk("alu_sra", dut.rf[11], 32'hFFFF_FFFE);
      // asynchronous reset mid-program takes effect before the next edge
      rstn = 1'b1;
      #1;
      chk("midrst_pc", dut.pc, 32'h0);
      chk("midrst_x3", dut.rf[3], 32'h0);
      chk("midrst_x1", dut.rf[1], 32'h0);

      // ---------------- memory ----------------
      begin_phase();
      put(32'h00, ei(32'h80, 0, 0, 1, IMM)); // addi x1,x0,0x80
      put(32'h04, eu(32'hDEADC, 2, LUI));    // lui  x2,0xDEADC
      put(32'h08, ei(-273, 2, 0, 2, IMM));   // addi x2,x2,-0x111 -> DEADBEEF
      put(32'h0C, es(0, 2, 1, 2));           // sw   x2,0(x1)
      put(32'h10, ei(1, 1, 0, 7, LD));       // lb   x7,1(x1)
      put(32'h14, ei(2, 1, 5, 8, LD));       // lhu  x8,2(x1)
      put(32'h18, ei(32'h55, 0, 0, 3, IMM)); // addi x3,x0,0x55
      put(32'h1C, es(3, 3, 1, 0));           // sb   x3,3(x1)
      put(32'h20, ei(0, 1, 2, 9, LD));       // lw   x9,0(x1)
      put(32'h24, ei(2, 1, 1, 10, LD));      // lh   x10,2(x1)
      put(32'h28, ei(1, 1, 4, 13, LD));      // lbu  x13,1(x1)
      put(32'h2C, ei(0, 1, 1, 14, LD));      // lh   x14,0(x1)
      put(32'h30, es(2, 3, 1, 1));           // sh   x3,2(x1)
      put(32'h34, ei(0, 1, 2, 15, LD));      // lw   x15,0(x1)
      put(32'h38, ei(2, 1, 2, 16, LD));      // lw   x16,2(x1) misaligned
      release_rst();
      step(4);
      chk("mem_sw", dut.dram[32], 32'hDEAD_BEEF);
      step(11);
      chk("mem_pc", dut.pc, 32'h3C);
      chk("mem_lb", dut.rf[7], 32'hFFFF_FFBE);
      chk("mem_lhu", dut.rf[8], 32'h0000_DEAD);
      chk("mem_sb_lw", dut.rf[9], 32'h55AD_BEEF);
      chk("mem_lh_pos", dut.rf[10], 32'h0000_55AD);
      chk("mem_lbu", dut.rf[13], 32'h0000_00BE);
      chk("mem_lh_neg", dut.rf[14], 32'hFFFF_BEEF);
      chk("mem_sh_lw", dut.rf[15], 32'h0055_BEEF);
      chk("mem_misalign", dut.rf[16], 32'h0055_BEEF);
      chk("mem_word", dut.dram[32], 32'h0055_BEEF);

      // ---------------- control flow ----------------
      begin_phase();
      put(32'h00, ei(1, 0, 0, 1, IMM));      // addi x1,x0,1
      put(32'h04, ei(1, 0, 0, 2, IMM));      // addi x2,x0,1
      put(32'h08, ei(2, 0, 0, 3, IMM));      // addi x3,x0,2
      put(32'h0C, 32'h0000_0073);            // ecall -> NOP
      put(32'h10, eb(8, 2, 1, 0));           // beq  x1,x2,+8
      put(32'h14, ei(99, 0, 0, 4, IMM));     // addi x4,x0,99 (skipped)
      put(32'h18, eb(8, 2, 1, 1));           // bne  x1,x2,+8 (not taken)
      put(32'h1C, ei(7, 0, 0, 5, IMM));      // addi x5,x0,7
      put(32'h20, ej(12, 1));                // jal  x1,+12
      put(32'h24, ei(5, 0, 0, 6, IMM));      // addi x6,x0,5
      put(32'h28, ej(8, 0));                 // jal  x0,+8
      put(32'h2C, ei(0, 1, 0, 0, JALR));     // jalr x0,0(x1)
      release_rst();
      step(4);
      chk("cf_ecall_pc", dut.pc, 32'h10);
      step(1);
      chk("cf_beq_taken", dut.pc, 32'h18);
      step(1);
      chk("cf_bne_nt", dut.pc, 32'h1C);
      step(2);
      chk("cf_jal_pc", dut.pc, 32'h2C);
      chk("cf_jal_link", dut.rf[1], 32'h24);
      step(1);
      chk("cf_jalr_pc", dut.pc, 32'h24);
      step(2);
      chk("cf_end_pc", dut.pc, 32'h30);
      chk("cf_x4_skip", dut.rf[4], 32'h0);
      chk("cf_x5", dut.rf[5], 32'h7);
      chk("cf_x6", dut.rf[6], 32'h5);

      // ---------------- x0, LUI, AUIPC, pc wrap ----------------
      begin_phase();
      put(32'h00, ei(7, 0, 0, 0, IMM));      // addi x0,x0,7
      put(32'h04, eu(32'h12345, 9, LUI));    // lui  x9,0x12345
      put(32'h40, eu(1, 10, AUIPC));         // auipc x10,1
      put(32'h44, ej(-72, 0));               // jal  x0,-0x48 -> wraps to 0x3FC
      release_rst();
      step(1);
      chk("x0_zero", dut.rf[0], 32'h0);
      step(16);
      chk("lui_pc", dut.pc, 32'h44);
      chk("lui_x9", dut.rf[9], 32'h1234_5000);
      chk("auipc_x10", dut.rf[10], 32'h0000_1040);
      step(1);
      chk("wrap_neg", dut.pc, 32'h3FC);
      step(1);
      chk("wrap_top", dut.pc, 32'h0);

      // ---------------- full program ----------------
      begin_phase();
      put(32'h00, ei(5, 0, 0, 1, IMM));       // addi x1,x0,5
      put(32'h04, ei(-2, 0, 0, 2, IMM));      // addi x2,x0,-2
      put(32'h08, er(32, 2, 1, 0, 3));        // sub  x3,x1,x2
      put(32'h0C, er(0, 2, 1, 4, 4));         // xor  x4,x1,x2
      put(32'h10, er(0, 2, 1, 6, 5));         // or   x5,x1,x2
      put(32'h14, er(0, 2, 1, 7, 6));         // and  x6,x1,x2
      put(32'h18, er(0, 1, 1, 1, 7));         // sll  x7,x1,x1
      put(32'h1C, er(0, 1, 2, 5, 8));         // srl  x8,x2,x1
      put(32'h20, ei(-1, 1, 3, 9, IMM));      // sltiu x9,x1,-1
      put(32'h24, ei(-1, 2, 2, 10, IMM));     // slti x10,x2,-1
      put(32'h28, ei(-1, 1, 4, 11, IMM));     // xori x11,x1,-1
      put(32'h2C, ei(48, 1, 6, 12, IMM));     // ori  x12,x1,0x30
      put(32'h30, ei(240, 2, 7, 13, IMM));    // andi x13,x2,0xF0
      put(32'h34, ei(28, 1, 1, 14, IMM));     // slli x14,x1,28
      put(32'h38, ei(28, 2, 5, 15, IMM));     // srli x15,x2,28
      put(32'h3C, ei(3, 0, 0, 16, IMM));      // addi x16,x0,3
      put(32'h40, ei(2, 17, 0, 17, IMM));     // addi x17,x17,2
      put(32'h44, ei(-1, 16, 0, 16, IMM));    // addi x16,x16,-1
      put(32'h48, eb(-8, 16, 0, 4));          // blt  x0,x16,-8
      put(32'h4C, eb(8, 1, 2, 5));            // bge  x2,x1,+8 (not taken)
      put(32'h50, eb(8, 2, 1, 6));            // bltu x1,x2,+8 (taken)
      put(32'h54, ei(1, 0, 0, 18, IMM));      // addi x18,x0,1 (skipped)
      put(32'h58, eb(8, 1, 2, 7));            // bgeu x2,x1,+8 (taken)
      put(32'h5C, ei(1, 0, 0, 19, IMM));      // addi x19,x0,1 (skipped)
      put(32'h60, eu(0, 20, AUIPC));          // auipc x20,0
      put(32'h64, ei(13, 20, 0, 21, JALR));   // jalr x21,13(x20) -> 0x6C
      put(32'h68, ei(1, 0, 0, 22, IMM));      // addi x22,x0,1 (skipped)
      put(32'h6C, es(256, 3, 0, 2));          // sw   x3,0x100(x0)
      put(32'h70, ei(256, 0, 2, 23, LD));     // lw   x23,0x100(x0)
      put(32'h74, es(257, 1, 0, 0));          // sb   x1,0x101(x0)
      put(32'h78, ej(0, 0));                  // jal  x0,0
      for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
      exp_rf[1]  = 32'h0000_0005;  exp_rf[2]  = 32'hFFFF_FFFE;
      exp_rf[3]  = 32'h0000_0007;  exp_rf[4]  = 32'hFFFF_FFFB;
      exp_rf[5]  = 32'hFFFF_FFFF;  exp_rf[6]  = 32'h0000_0004;
      exp_rf[7]  = 32'h0000_00A0;  exp_rf[8]  = 32'h07FF_FFFF;
      exp_rf[9]  = 32'h0000_0001;  exp_rf[10] = 32'h0000_0001;
      exp_rf[11] = 32'hFFFF_FFFA;  exp_rf[12] = 32'h0000_0035;
      exp_rf[13] = 32'h0000_00F0;  exp_rf[14] = 32'h5000_0000;
      exp_rf[15] = 32'h0000_000F;  exp_rf[17] = 32'h0000_0006;
      exp_rf[20] = 32'h0000_0060;  exp_rf[21] = 32'h0000_0068;
      exp_rf[23] = 32'h0000_0007;
      release_rst();
      cyc = 0;
      while (dut.pc !== 32'h78 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("full_reach", dut.pc, 32'h78);
      chk("full_cycles", cyc, 33);
      for (int i = 1; i < 32; i++) chk($sformatf("full_x%0d", i), dut.rf[i], exp_rf[i]);
      chk("full_dmem", dut.dram[64], 32'h0000_0507);
      step(1);
      chk("full_hold", dut.pc, 32'h78);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
